// File: rtl/pow2_scale_ctrl.sv
// Streaming power-of-two scaler for complex IEEE-754 single samples with a
// frame-locked shift: the active shift only changes between frames.
module pow2_scale_ctrl #(
  parameter int unsigned FRAME_LEN = 125,
  parameter int unsigned CNT_W     = 7,
  parameter int unsigned RST_SHIFT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  cfg_shift,
  input  logic        cfg_load,
  input  logic        uflow_clr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_re,
  input  logic [31:0] in_img,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_re,
  output logic [31:0] out_img,
  output logic        out_last,
  output logic        busy,
  output logic        uflow
);

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned EXP_W   = 8;
  localparam int unsigned MANT_W  = 23;
  localparam int unsigned SHIFT_W = 5;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

  logic [0:0]         state, state_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic [SHIFT_W-1:0] k, k_next;
  logic [SHIFT_W-1:0] pend_shift, pend_shift_next;
  logic               pend_vld, pend_vld_next;

  logic               accept;
  logic               is_last;
  logic [WORD_W:0]    re_s, img_s;
  logic               uf_now;

  // Returns {underflow, scaled word}; exponent edge cases handled before the subtract.
  function automatic logic [WORD_W:0] scale_word(input logic [WORD_W-1:0] w,
                                                 input logic [SHIFT_W-1:0] sh);
    logic [EXP_W-1:0] e;
    e = w[WORD_W-2 -: EXP_W];
    if (e == '1) begin
      scale_word = {1'b0, w};
    end else if (e == '0) begin
      scale_word = {1'b0, w[WORD_W-1], (WORD_W-1)'(0)};
    end else if (e <= EXP_W'(sh)) begin
      scale_word = {1'b1, w[WORD_W-1], (WORD_W-1)'(0)};
    end else begin
      scale_word = {1'b0, w[WORD_W-1], e - EXP_W'(sh), w[MANT_W-1:0]};
    end
  endfunction

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign is_last  = accept && (cnt == LAST_IDX);

  assign re_s   = scale_word(in_re, k);
  assign img_s  = scale_word(in_img, k);
  assign uf_now = accept && (re_s[WORD_W] || img_s[WORD_W]);

  // Frame sequencer and shift configuration next-state logic.
  always_comb begin
    state_next      = state;
    cnt_next        = cnt;
    k_next          = k;
    pend_shift_next = pend_shift;
    pend_vld_next   = pend_vld;

    if (accept) begin
      if (is_last) begin
        cnt_next   = '0;
        state_next = IDLE;
      end else begin
        cnt_next   = cnt + CNT_W'(1);
        state_next = RUN;
      end
    end

    if (is_last) begin
      // A strobe on the boundary beats an older pending value.
      if (cfg_load) begin
        k_next = cfg_shift;
      end else if (pend_vld) begin
        k_next = pend_shift;
      end
      pend_vld_next = 1'b0;
    end else if (cfg_load) begin
      if (state == IDLE && !accept) begin
        k_next = cfg_shift;
      end else begin
        pend_shift_next = cfg_shift;
        pend_vld_next   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      k          <= SHIFT_W'(RST_SHIFT);
      pend_shift <= '0;
      pend_vld   <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      k          <= k_next;
      pend_shift <= pend_shift_next;
      pend_vld   <= pend_vld_next;
    end
  end

  // Single output register; holds its contents while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_re    <= '0;
      out_img   <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      uflow     <= 1'b0;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        out_re    <= re_s[WORD_W-1:0];
        out_img   <= img_s[WORD_W-1:0];
        out_last  <= is_last;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      busy  <= (state_next == RUN);
      uflow <= uf_now || (uflow && !uflow_clr);
    end
  end

endmodule

// File: tb/tb_pow2_scale_ctrl.sv
// Self-checking bench for pow2_scale_ctrl: edge-case vector table, directed
// frame/config/backpressure/reset sequences, and randomized traffic vs a model.
module tb_pow2_scale_ctrl;

  localparam int FL = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  cfg_shift;
  logic        cfg_load;
  logic        uflow_clr;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_re, in_img;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_re, out_img;
  logic        out_last;
  logic        busy;
  logic        uflow;

  pow2_scale_ctrl #(.FRAME_LEN(FL), .CNT_W(3), .RST_SHIFT(3)) dut (
    .clk(clk), .rst(rst), .cfg_shift(cfg_shift), .cfg_load(cfg_load),
    .uflow_clr(uflow_clr), .in_valid(in_valid), .in_ready(in_ready),
    .in_re(in_re), .in_img(in_img), .out_valid(out_valid), .out_ready(out_ready),
    .out_re(out_re), .out_img(out_img), .out_last(out_last), .busy(busy),
    .uflow(uflow)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state, in frame/sample terms.
  bit          m_ov, m_last, m_uflow, m_pvld;
  logic [31:0] m_re, m_im;
  int          m_idx, m_k, m_pend;

  typedef struct {
    logic [31:0] re, img, exp_re, exp_img;
    bit          exp_uf;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_scale(input logic [31:0] w, input int k, output bit uf);
    int e;
    e  = int'(w[30:23]);
    uf = 1'b0;
    if (e == 255) return w;
    if (e == 0) return {w[31], 31'd0};
    if (e <= k) begin
      uf = 1'b1;
      return {w[31], 31'd0};
    end
    return {w[31], 8'(e - k), w[22:0]};
  endfunction

  task automatic model_reset();
    m_ov = 0; m_last = 0; m_uflow = 0; m_pvld = 0;
    m_re = '0; m_im = '0; m_idx = 0; m_k = 3; m_pend = 0;
  endtask

  // One clock: check ready, advance the model, then check registered outputs.
  task automatic cycle();
    bit rdy, acc, last, u1, u2;
    #1;
    rdy = !m_ov || out_ready;
    chk("in_ready", 32'(in_ready), 32'(rdy));
    if (rst) begin
      model_reset();
    end else begin
      acc  = in_valid && rdy;
      last = acc && (m_idx == FL - 1);
      u1 = 0; u2 = 0;
      if (acc) begin
        m_re   = ref_scale(in_re, m_k, u1);
        m_im   = ref_scale(in_img, m_k, u2);
        m_ov   = 1;
        m_last = last;
      end else if (out_ready) begin
        m_ov = 0;
      end
      if (last) begin
        if (cfg_load) m_k = int'(cfg_shift);
        else if (m_pvld) m_k = m_pend;
        m_pvld = 0;
      end else if (cfg_load) begin
        if (m_idx == 0 && !acc) m_k = int'(cfg_shift);
        else begin
          m_pend = int'(cfg_shift);
          m_pvld = 1;
        end
      end
      if (acc) m_idx = last ? 0 : m_idx + 1;
      m_uflow = (acc && (u1 || u2)) || (m_uflow && !uflow_clr);
    end
    @(posedge clk);
    #1;
    chk("out_valid", 32'(out_valid), 32'(m_ov));
    chk("busy", 32'(busy), 32'(m_idx != 0));
    chk("uflow", 32'(uflow), 32'(m_uflow));
    if (m_ov) begin
      chk("out_re", out_re, m_re);
      chk("out_img", out_img, m_im);
      chk("out_last", 32'(out_last), 32'(m_last));
    end
  endtask

  task automatic send(input logic [31:0] re, input logic [31:0] img);
    in_valid = 1'b1;
    in_re    = re;
    in_img   = img;
    cycle();
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; cfg_load = 1'b0; uflow_clr = 1'b0; out_ready = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  function automatic logic [31:0] rand_word();
    logic [7:0] e;
    case ($urandom_range(0, 5))
      0: e = 8'd0;
      1: e = 8'd255;
      2: e = 8'($urandom_range(1, 8));
      default: e = 8'($urandom);
    endcase
    return {1'($urandom), e, 23'($urandom)};
  endfunction

  vec_t vecs[5];
  logic [31:0] held;

  initial begin
    vecs[0] = '{32'h41000000, 32'hC1000000, 32'h3F800000, 32'hBF800000, 1'b0};
    vecs[1] = '{32'h01800000, 32'h80000001, 32'h00000000, 32'h80000000, 1'b1};
    vecs[2] = '{32'h7F800000, 32'h7FC00001, 32'h7F800000, 32'h7FC00001, 1'b1};
    vecs[3] = '{32'h00000000, 32'h3F800000, 32'h00000000, 32'h3E000000, 1'b1};
    vecs[4] = '{32'h02000000, 32'h81800000, 32'h00800000, 32'h80000000, 1'b1};

    rst = 1'b1; cfg_shift = '0; cfg_load = 1'b0; uflow_clr = 1'b0;
    in_valid = 1'b0; in_re = '0; in_img = '0; out_ready = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_re", out_re, 32'd0);
    chk("rst_out_img", out_img, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_uflow", 32'(uflow), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Edge-case table at k = 3 (exactly one frame).
    for (int i = 0; i < 5; i++) begin
      send(vecs[i].re, vecs[i].img);
      chk("vec_re", out_re, vecs[i].exp_re);
      chk("vec_img", out_img, vecs[i].exp_img);
      chk("vec_uflow", 32'(uflow), 32'(vecs[i].exp_uf));
    end
    in_valid = 1'b0;

    // Clear alongside a new underflow: set wins.
    uflow_clr = 1'b1;
    send(32'h01800000, 32'h40000000);
    chk("uflow_set_wins", 32'(uflow), 32'd1);
    in_valid = 1'b0;
    cycle();
    chk("uflow_cleared", 32'(uflow), 32'd0);
    uflow_clr = 1'b0;

    // Frame sequencing: 12 back-to-back samples.
    do_reset();
    for (int n = 1; n <= 12; n++) begin
      send(32'h41000000 + 32'(n), 32'h41000000);
      chk("frame_last", 32'(out_last), 32'((n == 5) || (n == 10)));
      chk("frame_busy", 32'(busy), 32'((n % 5) != 0));
    end
    in_valid = 1'b0;
    cycle();

    // Mid-frame config: new shift only takes effect next frame.
    do_reset();
    send(32'h41000000, 32'h41000000);
    cfg_load = 1'b1; cfg_shift = 5'd1;
    send(32'h41000000, 32'h41000000);
    cfg_load = 1'b0;
    chk("midcfg_s2", out_re, 32'h3F800000);
    for (int n = 3; n <= 5; n++) begin
      send(32'h41000000, 32'h41000000);
      chk("midcfg_old_k", out_re, 32'h3F800000);
    end
    send(32'h41000000, 32'hC1000000);
    chk("midcfg_new_re", out_re, 32'h40800000);
    chk("midcfg_new_img", out_img, 32'hC0800000);
    in_valid = 1'b0;
    cycle();

    // Backpressure: outputs freeze and input is refused.
    do_reset();
    send(32'h41000000, 32'h41000000);
    send(32'h41800000, 32'h41800000);
    held = out_re;
    out_ready = 1'b0;
    for (int n = 0; n < 3; n++) begin
      send(32'h42000000, 32'h42000000);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_frozen", out_re, held);
    end
    out_ready = 1'b1;
    send(32'h42000000, 32'h42000000);
    chk("bp_resume", out_re, 32'h40800000);
    in_valid = 1'b0;
    cycle();
    chk("bp_drain", 32'(out_valid), 32'd0);

    // Reset mid-frame with a pending shift.
    do_reset();
    send(32'h41000000, 32'h41000000);
    cfg_load = 1'b1; cfg_shift = 5'd1;
    send(32'h41000000, 32'h41000000);
    cfg_load = 1'b0;
    send(32'h41000000, 32'h41000000);
    rst = 1'b1; in_valid = 1'b0;
    cycle();
    rst = 1'b0;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    for (int n = 1; n <= 5; n++) begin
      send(32'h41000000, 32'h41000000);
      chk("midrst_k3", out_re, 32'h3F800000);
      chk("midrst_last", 32'(out_last), 32'(n == 5));
    end
    in_valid = 1'b0;
    cycle();

    // Randomized traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      rst       = ($urandom_range(0, 199) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      cfg_load  = ($urandom_range(0, 9) == 0);
      cfg_shift = 5'($urandom_range(0, 31));
      uflow_clr = ($urandom_range(0, 7) == 0);
      in_re     = rand_word();
      in_img    = rand_word();
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pow2_scale_ctrl.md
# pow2_scale_ctrl

Streaming power-of-two scaler and frame sequencer for complex IEEE-754 single-precision samples in the Radix-5 FFT datapath. It divides each sample by 2^shift by subtracting from the exponent field, and replaces the fixed divide-by-8 stage with a configurable, frame-locked one. It handles the exponent edge cases that a bare subtract gets wrong: zero, denormal, underflow, Inf and NaN. It sits between a butterfly stage output and the next stage or output buffer, with valid/ready on both sides.

## Interface
- FRAME_LEN, 125: samples per frame (25 or 125 for radix-5 use); must be ≥ 2.
- CNT_W, 7: sample counter width; must satisfy 2^CNT_W ≥ FRAME_LEN.
- RST_SHIFT, 3: active shift after reset (divide by 8).

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- cfg_shift  in  5  requested shift amount, 0..31.
- cfg_load  in  1  one-cycle strobe that requests cfg_shift.
- uflow_clr  in  1  clears the uflow sticky flag.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept an input sample.
- in_re, in_img  in  32 each  input sample, IEEE-754 single.
- out_valid  out  1  output register holds a sample.
- out_ready  in  1  downstream accepts the output.
- out_re, out_img  out  32 each  scaled sample.
- out_last  out  1  output is the last sample of its frame.
- busy  out  1  a frame is in progress (state RUN).
- uflow  out  1  sticky flag: at least one component underflowed to zero.

## Operation
- Accept: an input is accepted when in_valid && in_ready. An output is consumed when out_valid && out_ready.
- Component rule, applied to re and img independently. s = bit31, e = bits 30:23, m = bits 22:0, k = active shift.
  - e == 255: pass the word unchanged (Inf/NaN).
  - e == 0: output {s, 31'b0} (zero or denormal flushed to signed zero).
  - 0 < e ≤ k: output {s, 31'b0} and set uflow.
  - otherwise: output {s, e−k, m}.
  - k == 0 is a bit-exact pass-through except that denormals are flushed.
- State machine:
  - IDLE: no frame open. The first accept moves to RUN with sample_cnt = 1, unless FRAME_LEN is reached on that same accept.
  - RUN: each accept increments sample_cnt. The accept with sample_cnt == FRAME_LEN−1 is tagged last; on it sample_cnt wraps to 0 and the state returns to IDLE.
- Shift configuration:
  - Active shift (k) is only changed in IDLE or at a frame boundary.
  - cfg_load in IDLE with no accept that cycle: k ← cfg_shift the next cycle.
  - cfg_load in RUN, or in IDLE together with an accept: the value goes to pend_shift and pend_vld is set. The current frame keeps the old k.
  - On the last-sample accept: if pend_vld, k ← pend_shift and pend_vld is cleared. A cfg_load on that same cycle takes priority over an older pending value.
  - Several cfg_load strobes within one frame: the last one wins.
- uflow: uflow_clr and a new underflow in the same cycle leave uflow = 1 (set wins).
- busy = (state == RUN).

## Timing
- Latency: 1 cycle from accept to out_valid, through a single output register.
- in_ready = !out_valid || out_ready. This gives full throughput of one sample per cycle with no bubbles.
- Under backpressure (out_valid && !out_ready), out_re, out_img and out_last hold stable and no input is accepted.
- out_last is registered together with its sample and is valid only while out_valid = 1.
- Reset values: out_valid 0, out_re 0, out_img 0, out_last 0, busy 0, uflow 0, state IDLE, sample_cnt 0, k = RST_SHIFT, pend_vld 0.
- Reset mid-frame drops the sample held in the output register and any pending shift. The next accept starts a new frame at index 0.
- in_ready is 1 in the cycle after reset deasserts.

## Test plan
- Basic scaling after reset (k = 3): in_re 0x41000000, in_img 0xC1000000 → one cycle later out_re 0x3F800000, out_img 0xBF800000, uflow 0.
- Edge cases, k = 3:
  - re 0x01800000 (e = 3) → 0x00000000, uflow 1.
  - img 0x80000001 (denormal) → 0x80000000.
  - 0x7F800000 and 0x7FC00001 → unchanged.
  - uflow_clr together with a new underflow → uflow stays 1.
- Frame sequencing, FRAME_LEN = 5: stream 12 back-to-back samples → out_last on outputs 5 and 10. busy drops in the cycle after the 5th and 10th accepts and rises again on the 6th and 11th.
- Mid-frame configuration: cfg_load with shift 1 on the 2nd accept of a frame → samples 2–5 use k = 3; the next frame's sample 0x41000000 → 0x40800000.
- Backpressure: hold out_ready = 0 for 3 cycles while in_valid = 1 → in_ready 0, outputs frozen. Then all samples come out in order with none lost or duplicated.
- Reset mid-frame (after 3 of 5 samples) with a pending shift: out_valid 0, k = 3. The next 5 samples form a full frame with out_last on the 5th.
